// File: rtl/traffic_sink.sv
// Ejection endpoint: per-VC packet framing checks, delayed credit return, flit/packet counters.
// Define TRAFFIC_SINK_LATENCY_EN to add per-packet latency statistics (lat_max, lat_sum).
module traffic_sink #(
    parameter int NUM_VC           = 4,
    parameter int VC_W             = 2,
    parameter int DST_W            = 4,
    parameter int DATA_W           = 16,
    parameter int CNT_W            = 16,
    parameter int MAX_CREDIT_DELAY = 7,
    parameter int DLY_W            = $clog2(MAX_CREDIT_DELAY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DST_W-1:0]  my_id,
    input  logic              init,
    input  logic [DLY_W-1:0]  credit_delay,
    input  logic [CNT_W-1:0]  expected_pkts,
    input  logic [CNT_W-1:0]  in_cycle,
    input  logic              flit_valid,
    input  logic              flit_head,
    input  logic              flit_tail,
    input  logic [VC_W-1:0]   flit_vc,
    input  logic [DST_W-1:0]  flit_dst,
    input  logic [DATA_W-1:0] flit_data,
    output logic              credit_valid,
    output logic [VC_W-1:0]   credit_vc,
    output logic [CNT_W-1:0]  flit_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              err_frame,
    output logic              err_dst,
    output logic              done
`ifdef TRAFFIC_SINK_LATENCY_EN
    ,
    output logic [CNT_W-1:0]   lat_max,
    output logic [2*CNT_W-1:0] lat_sum
`endif
);

    localparam int NSLOT = MAX_CREDIT_DELAY + 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} vc_state_t;

    vc_state_t        state_q [NUM_VC];
    vc_state_t        state_d [NUM_VC];
    logic [DLY_W-1:0] delay_q;
    logic [CNT_W-1:0] expected_q;
    logic             slot_v  [NSLOT];
    logic [VC_W-1:0]  slot_vc [NSLOT];

    logic accept;
    logic cur_busy;
    logic pkt_inc;
    logic frame_err;
    logic dst_err;

    // init wins over a same-cycle flit: that flit is dropped entirely
    assign accept   = flit_valid & ~init;
    assign cur_busy = (state_q[flit_vc] == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_VC; i++) state_q[i] <= IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_VC; i++) state_d[i] = state_q[i];
        if (accept) begin
            if (flit_head)
                state_d[flit_vc] = flit_tail ? IDLE : BUSY;
            else if (cur_busy && flit_tail)
                state_d[flit_vc] = IDLE;
        end
    end

    // A head while BUSY restarts the packet, so it counts its tail like a head from IDLE
    always_comb begin
        pkt_inc   = accept & flit_tail & (flit_head | cur_busy);
        frame_err = accept & (flit_head ? cur_busy : ~cur_busy);
        dst_err   = accept & flit_head & (flit_dst != my_id);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q    <= '0;
            expected_q <= '0;
            flit_count <= '0;
            pkt_count  <= '0;
            err_frame  <= 1'b0;
            err_dst    <= 1'b0;
            done       <= 1'b0;
        end else if (init) begin
            delay_q    <= (int'(credit_delay) > MAX_CREDIT_DELAY) ?
                          DLY_W'(MAX_CREDIT_DELAY) : credit_delay;
            expected_q <= expected_pkts;
            flit_count <= '0;
            pkt_count  <= '0;
            err_frame  <= 1'b0;
            err_dst    <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept)    flit_count <= flit_count + 1'b1;
            if (pkt_inc)   pkt_count  <= pkt_count + 1'b1;
            if (frame_err) err_frame  <= 1'b1;
            if (dst_err)   err_dst    <= 1'b1;
            done <= (pkt_count == expected_q) && (expected_q != '0);
        end
    end

    // Credit line: new entry lands at slot D, everything moves one slot toward 0 per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_v[i]  <= 1'b0;
                slot_vc[i] <= '0;
            end
            credit_valid <= 1'b0;
            credit_vc    <= '0;
        end else begin
            for (int unsigned i = 0; i < NSLOT - 1; i++) begin
                slot_v[i]  <= slot_v[i+1];
                slot_vc[i] <= slot_vc[i+1];
            end
            slot_v[NSLOT-1]  <= 1'b0;
            slot_vc[NSLOT-1] <= '0;
            if (accept) begin
                slot_v[delay_q]  <= 1'b1;
                slot_vc[delay_q] <= flit_vc;
            end
            credit_valid <= slot_v[0];
            if (slot_v[0]) credit_vc <= slot_vc[0];
        end
    end

`ifdef TRAFFIC_SINK_LATENCY_EN
    logic [CNT_W-1:0] stamp_q [NUM_VC];
    logic [CNT_W-1:0] head_stamp;
    logic [CNT_W-1:0] lat;

    // single-flit packets carry their own stamp
    assign head_stamp = flit_head ? flit_data[CNT_W-1:0] : stamp_q[flit_vc];
    assign lat        = in_cycle - head_stamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_VC; i++) stamp_q[i] <= '0;
            lat_max <= '0;
            lat_sum <= '0;
        end else if (init) begin
            lat_max <= '0;
            lat_sum <= '0;
        end else begin
            if (accept && flit_head) stamp_q[flit_vc] <= flit_data[CNT_W-1:0];
            if (pkt_inc) begin
                lat_sum <= lat_sum + {{CNT_W{1'b0}}, lat};
                if (lat > lat_max) lat_max <= lat;
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{flit_data, in_cycle};
`endif

endmodule
